computie_bus_master_ctrl: RTL

//  Bus-master sequencer for the multiplexed 32-bit address/data Computie bus.

---
 rtl/computie_bus_master_ctrl_if.sv | 36 +++
 rtl/computie_bus_master_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/computie_bus_master_ctrl_if.sv
// Computie bus master signal bundle: local request/response side plus the
// multiplexed AD pad demux and bus strobes.
interface computie_bus_master_ctrl_if #(
  parameter int BITWIDTH = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [BITWIDTH-1:0] req_addr;
  logic [BITWIDTH-1:0] req_wdata;
  logic                rsp_valid;
  logic                rsp_error;
  logic [BITWIDTH-1:0] rsp_rdata;
  logic                ad_oe;
  logic [BITWIDTH-1:0] ad_out;
  logic [BITWIDTH-1:0] ad_in;
  logic                as_n;
  logic                ds_n;
  logic                write_n;
  logic                ack_n;
  logic                berr_n;

  // Controller view.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, ad_in, ack_n, berr_n,
    output req_ready, rsp_valid, rsp_error, rsp_rdata, ad_oe, ad_out,
           as_n, ds_n, write_n
  );

  // Requester / pad / target view.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, ad_in, ack_n, berr_n,
    input  req_ready, rsp_valid, rsp_error, rsp_rdata, ad_oe, ad_out,
           as_n, ds_n, write_n
  );
endinterface

// File: rtl/computie_bus_master_ctrl.sv
// Bus-master sequencer for the multiplexed Computie AD bus.
//
//  state  | meaning
//  IDLE   | ready for a request, bus released
//  ADDR   | one cycle address phase, controller drives AD
//  TURN   | read turnaround, AD released, no data strobe
//  DATA_W | write data phase, controller drives AD, waits for ack/berr/timeout
//  DATA_R | read data phase, target drives AD, waits for ack/berr/timeout
//  END    | response strobe and bus recovery cycle
module computie_bus_master_ctrl #(
  parameter int BITWIDTH       = 32,
  parameter int TURNAROUND     = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                         clock,
  input logic                         reset_n,
  computie_bus_master_ctrl_if.master  bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + TURNAROUND + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_TURN, S_DATA_W, S_DATA_R, S_END
  } state_t;

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic                write_q;
  logic [CNT_W-1:0]    cnt_q;

  logic ack, berr, turn_last, tmo_last, in_data;
  assign ack       = ~bus.ack_n;
  assign berr      = ~bus.berr_n;
  assign turn_last = (cnt_q == CNT_W'(TURNAROUND - 1));
  assign tmo_last  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign in_data   = (state_q == S_DATA_W) || (state_q == S_DATA_R);

  // Next-state outputs are computed combinationally and registered so the pads see clean levels.
  logic                oe_d, as_n_d, ds_n_d, write_n_d, ready_d, rsp_valid_d, rsp_error_d;
  logic [BITWIDTH-1:0] ad_out_d;
  logic                oe_q, as_n_q, ds_n_q, write_n_q, ready_q, rsp_valid_q, rsp_error_q;
  logic [BITWIDTH-1:0] ad_out_q;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; berr, then ack, then timeout decide the data phase exit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.req_valid) state_d = S_ADDR;
      S_ADDR:   state_d = write_q ? S_DATA_W : S_TURN;
      S_TURN:   if (turn_last) state_d = S_DATA_R;
      S_DATA_W,
      S_DATA_R: if (berr || ack || tmo_last) state_d = S_END;
      S_END:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state; the address is taken straight from the request on accept.
  always_comb begin
    oe_d        = 1'b0;
    ad_out_d    = '0;
    as_n_d      = 1'b1;
    ds_n_d      = 1'b1;
    write_n_d   = 1'b1;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    unique case (state_d)
      S_IDLE: ready_d = 1'b1;
      S_ADDR: begin
        oe_d      = 1'b1;
        ad_out_d  = bus.req_addr;
        as_n_d    = 1'b0;
        write_n_d = ~bus.req_write;
      end
      S_TURN: begin
        as_n_d    = 1'b0;
        write_n_d = ~write_q;
      end
      S_DATA_W: begin
        oe_d      = 1'b1;
        ad_out_d  = wdata_q;
        as_n_d    = 1'b0;
        ds_n_d    = 1'b0;
        write_n_d = ~write_q;
      end
      S_DATA_R: begin
        as_n_d    = 1'b0;
        ds_n_d    = 1'b0;
        write_n_d = ~write_q;
      end
      S_END: begin
        rsp_valid_d = 1'b1;
        // END is only entered from a data phase: anything but a clean ack is an error.
        rsp_error_d = berr || !ack;
      end
      default: ready_d = 1'b0;
    endcase
  end

  // Registered bus and response outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      oe_q        <= 1'b0;
      ad_out_q    <= '0;
      as_n_q      <= 1'b1;
      ds_n_q      <= 1'b1;
      write_n_q   <= 1'b1;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      oe_q        <= oe_d;
      ad_out_q    <= ad_out_d;
      as_n_q      <= as_n_d;
      ds_n_q      <= ds_n_d;
      write_n_q   <= write_n_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Request capture, phase counter and read data capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == S_IDLE && bus.req_valid) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        write_q <= bus.req_write;
      end
      if (state_q == S_TURN)  cnt_q <= turn_last ? '0 : cnt_q + 1'b1;
      else if (in_data)       cnt_q <= cnt_q + 1'b1;
      else                    cnt_q <= '0;
      if (state_q == S_DATA_R && ack && !berr) rdata_q <= bus.ad_in;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.ad_oe     = oe_q;
  assign bus.ad_out    = ad_out_q;
  assign bus.as_n      = as_n_q;
  assign bus.ds_n      = ds_n_q;
  assign bus.write_n   = write_n_q;
endmodule
